// File: rtl/str2bus_deser.sv
// Byte-stream to bus deserializer: packs BYTES stream bytes little-endian into a
// word and issues it as a single-beat write with an auto-incrementing address.
module str2bus_deser #(
  parameter int unsigned BYTES    = 4,
  parameter int unsigned AW       = 32,
  parameter int unsigned ADR_BASE = 0,
  parameter int unsigned ADR_INC  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 str_vld,
  input  logic [7:0]           str_bus,
  output logic                 str_rdy,
  output logic                 bso_vld,
  output logic [AW-1:0]        bso_adr,
  output logic [8*BYTES-1:0]   bso_dat,
  input  logic                 bso_rdy,
  output logic [15:0]          bso_cnt
);

  localparam int unsigned DW = 8 * BYTES;
  localparam int unsigned CW = $clog2(BYTES);
  localparam logic [AW-1:0] BASE = AW'(ADR_BASE);
  localparam logic [AW-1:0] INC  = AW'(ADR_INC);
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] pack_q, pack_d;
  logic          rdy_q, rdy_d;
  logic          vld_q, vld_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [15:0]   bcnt_q, bcnt_d;
  // Set when a flush arrives while a word is still waiting in the output register.
  logic          reld_q, reld_d;

  logic          str_trn;
  logic          bso_trn;
  logic [DW-1:0] pack_ins;

  assign str_trn = str_vld & rdy_q;
  assign bso_trn = vld_q & bso_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      pack_q <= '0;
      rdy_q  <= 1'b0;
      vld_q  <= 1'b0;
      adr_q  <= BASE;
      dat_q  <= '0;
      bcnt_q <= '0;
      reld_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      pack_q <= pack_d;
      rdy_q  <= rdy_d;
      vld_q  <= vld_d;
      adr_q  <= adr_d;
      dat_q  <= dat_d;
      bcnt_q <= bcnt_d;
      reld_q <= reld_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    pack_d   = pack_q;
    vld_d    = vld_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    bcnt_d   = bcnt_q;
    reld_d   = reld_q;
    pack_ins = pack_q;
    pack_ins[{cnt_q, 3'b000} +: 8] = str_bus;

    if (bso_trn) begin
      vld_d  = 1'b0;
      bcnt_d = bcnt_q + 16'd1;
      adr_d  = (reld_q | clr) ? BASE : adr_q + INC;
      reld_d = 1'b0;
    end

    // Flush beats any byte or pending-word activity this cycle.
    if (clr) begin
      cnt_d  = '0;
      pend_d = 1'b0;
      pack_d = '0;
      if (!vld_q) begin
        adr_d = BASE;
      end else if (!bso_trn) begin
        reld_d = 1'b1;
      end
    end else if (pend_q) begin
      if (bso_trn) begin
        dat_d  = pack_q;
        vld_d  = 1'b1;
        pend_d = 1'b0;
      end
    end else if (str_trn) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        if (!vld_q || bso_trn) begin
          dat_d = pack_ins;
          vld_d = 1'b1;
        end else begin
          pend_d = 1'b1;
          pack_d = pack_ins;
        end
      end else begin
        cnt_d  = cnt_q + CW'(1);
        pack_d = pack_ins;
      end
    end

    rdy_d = ~pend_d;
  end

  assign str_rdy = rdy_q;
  assign bso_vld = vld_q;
  assign bso_adr = adr_q;
  assign bso_dat = dat_q;
  assign bso_cnt = bcnt_q;

endmodule

// File: tb/tb_str2bus_deser.sv
// Scoreboard bench for str2bus_deser; a second AW=4 instance shares the stimulus
// so address wrap is checked alongside the main instance.
module tb_str2bus_deser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        str_vld = 1'b0;
  logic [7:0]  str_bus = 8'h00;
  logic        bso_rdy = 1'b0;
  logic        str_rdy, bso_vld;
  logic [31:0] bso_adr, bso_dat;
  logic [15:0] bso_cnt;
  logic        w_rdy, w_vld;
  logic [3:0]  w_adr;
  logic [31:0] w_dat;
  logic [15:0] w_cnt;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } word_t;

  word_t       sb[$];
  int          chk_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] exp_cnt = '0;
  logic [31:0] acc = '0;
  int          nb = 0;
  logic [31:0] next_adr = '0;
  int          wt;

  always #5 clk = ~clk;

  str2bus_deser u_dut (
    .clk(clk), .rst(rst), .clr(clr),
    .str_vld(str_vld), .str_bus(str_bus), .str_rdy(str_rdy),
    .bso_vld(bso_vld), .bso_adr(bso_adr), .bso_dat(bso_dat),
    .bso_rdy(bso_rdy), .bso_cnt(bso_cnt)
  );

  str2bus_deser #(.AW(4)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr),
    .str_vld(str_vld), .str_bus(str_bus), .str_rdy(w_rdy),
    .bso_vld(w_vld), .bso_adr(w_adr), .bso_dat(w_dat),
    .bso_rdy(bso_rdy), .bso_cnt(w_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bench model of the packer: accumulates accepted bytes, queues finished words.
  task automatic model_byte(input logic [7:0] b);
    acc[8*nb +: 8] = b;
    nb++;
    if (nb == 4) begin
      sb.push_back('{adr: next_adr, dat: acc});
      next_adr = next_adr + 32'd1;
      nb = 0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, output int waits);
    str_vld = 1'b1;
    str_bus = b;
    waits = 0;
    while (!str_rdy && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!str_rdy) begin
      chk("byte_accept_timeout", 64'(str_rdy), 64'd1);
      str_vld = 1'b0;
    end else begin
      @(negedge clk);
      str_vld = 1'b0;
      model_byte(b);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    nb = 0;
    next_adr = '0;
    repeat (2) @(negedge clk);
    chk("rst_str_rdy", 64'(str_rdy), 64'd0);
    chk("rst_bso_vld", 64'(bso_vld), 64'd0);
    chk("rst_bso_adr", 64'(bso_adr), 64'd0);
    chk("rst_bso_dat", 64'(bso_dat), 64'd0);
    chk("rst_bso_cnt", 64'(bso_cnt), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 64'(str_rdy), 64'd1);
  endtask

  // Output monitor: pops the scoreboard on every bus transfer.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      exp_cnt = '0;
    end else if (bso_vld && bso_rdy) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        word_t w;
        w = sb.pop_front();
        chk("bso_dat", 64'(bso_dat), 64'(w.dat));
        chk("bso_adr", 64'(bso_adr), 64'(w.adr));
        chk("bso_cnt", 64'(bso_cnt), 64'(exp_cnt));
        chk("wrap_vld", 64'(w_vld), 64'd1);
        chk("wrap_dat", 64'(w_dat), 64'(w.dat));
        chk("wrap_adr", 64'(w_adr), 64'(w.adr[3:0]));
        chk("wrap_cnt", 64'(w_cnt), 64'(exp_cnt));
      end
      exp_cnt = exp_cnt + 16'd1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single word with one-cycle latency
    do_reset();
    bso_rdy = 1'b1;
    send_byte(8'h11, wt);
    send_byte(8'h22, wt);
    send_byte(8'h33, wt);
    send_byte(8'h44, wt);
    chk("single_vld", 64'(bso_vld), 64'd1);
    chk("single_dat", 64'(bso_dat), 64'h44332211);
    chk("single_adr", 64'(bso_adr), 64'd0);
    @(negedge clk);
    chk("single_cnt", 64'(bso_cnt), 64'd1);
    chk("single_vld_drop", 64'(bso_vld), 64'd0);
    wait_drain();

    // Streaming at full rate
    do_reset();
    bso_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), wt);
      chk("stream_rdy_wait", 64'(wt), 64'd0);
    end
    wait_drain();

    // Backpressure: two words buffered, then release
    do_reset();
    bso_rdy = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i), wt);
    chk("bp_rdy_low", 64'(str_rdy), 64'd0);
    str_vld = 1'b1;
    str_bus = 8'hA8;
    repeat (3) begin
      @(negedge clk);
      chk("bp_rdy_hold", 64'(str_rdy), 64'd0);
    end
    bso_rdy = 1'b1;
    @(negedge clk);
    chk("bp_no_bubble_vld", 64'(bso_vld), 64'd1);
    chk("bp_second_dat", 64'(bso_dat), 64'hA7A6A5A4);
    for (int i = 8; i < 12; i++) send_byte(8'hA0 + 8'(i), wt);
    wait_drain();

    // Flush with a word in the output register: delivered, then address reloads
    bso_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), wt);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    next_adr = '0;
    chk("clr_hold_vld", 64'(bso_vld), 64'd1);
    chk("clr_hold_adr", 64'(bso_adr), 64'd3);
    bso_rdy = 1'b1;
    wait_drain();

    // Partial flush; the byte presented with clr must be dropped
    send_byte(8'h55, wt);
    send_byte(8'h66, wt);
    clr = 1'b1;
    str_vld = 1'b1;
    str_bus = 8'h77;
    @(negedge clk);
    clr = 1'b0;
    str_vld = 1'b0;
    nb = 0;
    next_adr = '0;
    chk("clr_rdy", 64'(str_rdy), 64'd1);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), wt);
    wait_drain();

    // Reset mid-operation with one word held and two bytes packed
    bso_rdy = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'hD0 + 8'(i), wt);
    do_reset();
    bso_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'hE0 + 8'(i), wt);
    wait_drain();

    // Address wrap on the AW=4 instance over 17 words
    do_reset();
    bso_rdy = 1'b1;
    for (int i = 0; i < 68; i++) send_byte(8'(i * 3), wt);
    wait_drain();
    chk("wrap_total_cnt", 64'(bso_cnt), 64'd17);
    chk("wrap_inst_cnt", 64'(w_cnt), 64'd17);
    chk("wrap_final_adr", 64'(w_adr), 64'd1);
    chk("wrap_rdy", 64'(w_rdy), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
